lsu_mem_port: RTL

- Load/store initiator between the single-cycle datapath's memory stage and the byte-wide synchronous data memory.
- Accepts one load or store request at a time over a valid/ready handshake, checks alignment and range, and drives the memory's addr/write_data/MemRead/MemWrite/data_type pins.
- For loads, waits for the memory's registered read data, then extracts, sign-extends or zero-extends the result and returns it over a valid/ready response channel.

---
 rtl/lsu_mem_port.sv | 132 +++++++++++++
 1 files changed

// File: rtl/lsu_mem_port.sv
// Load/store initiator between the memory stage and the byte-wide synchronous data memory.
// Handles one request at a time: validate, issue to memory, format load data, hold the response.
module lsu_mem_port #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_type,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [1:0]  SZ_WORD   = 2'd0;
    localparam logic [1:0]  SZ_HALF   = 2'd1;
    localparam logic [1:0]  SZ_BYTE   = 2'd2;
    localparam logic [1:0]  SZ_RSVD   = 2'd3;

    state_t              state_q, state_d;
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                req_bad;

    // Sign- or zero-extend the low byte/half of the memory word; words pass through.
    function automatic logic [31:0] format_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        b   = raw[7:0];
        h   = raw[15:0];
        ext = raw;
        case (size)
            SZ_BYTE: ext = uns ? $signed({24'd0, raw[7:0]})  : 32'(b);
            SZ_HALF: ext = uns ? $signed({16'd0, raw[15:0]}) : 32'(h);
            default: ext = raw;
        endcase
        return ext;
    endfunction

    always_comb begin
        req_bad = 1'b0;
        if (req_size == SZ_RSVD)                            req_bad = 1'b1;
        if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) req_bad = 1'b1;
        if ((req_size == SZ_HALF) && req_addr[0])           req_bad = 1'b1;
        if (req_addr >= MEM_LIMIT)                          req_bad = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    size_q  <= req_size;
                    uns_q   <= req_unsigned;
                    addr_q  <= req_addr[ADDR_W-1:0];
                    wdata_q <= req_wdata;
                    err_q   <= req_bad;
                    rdata_q <= 32'd0;
                end
                // mem_rdata is the memory's registered output from the ISSUE edge
                WAIT: rdata_q <= format_load(mem_rdata, size_q, uns_q);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_bad ? RESP : ISSUE;
            end
            ISSUE: begin
                mem_write = we_q;
                mem_read  = ~we_q;
                state_d   = we_q ? RESP : WAIT;
            end
            WAIT: state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_type   = size_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q & (state_q == RESP);

endmodule
